// File: rtl/adc_capture_writer_if.sv
// SDRAM write-request bus between the capture writer (master) and the SDRAM interface (slave).
interface adc_capture_writer_if;
    logic        req;
    logic        wnr;
    logic [21:0] address;
    logic [15:0] data;
    logic        busy;
    logic        ack;

    modport master (output req, wnr, address, data, input busy, ack);
    modport slave  (input req, wnr, address, data, output busy, ack);
endinterface

// File: rtl/adc_capture_writer.sv
// ADC capture writer: buffers ADC samples in a small FIFO and streams them to the SDRAM
// interface as sequential single-word writes.
// Optional feature: define ADC_CAPTURE_WRAP_EN for ring-buffer mode (address wraps inside
// the Length window, only Stop ends a capture, SamplesWritten saturates).
module adc_capture_writer #(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned FIFO_AW   = 4,
    parameter logic [21:0] BASE_ADDR = 22'h000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [21:0]          length,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    adc_capture_writer_if.master sdram,
    output logic                 active,
    output logic                 done,
    output logic                 overflow,
    output logic [21:0]          samples_written
);

`ifdef ADC_CAPTURE_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    localparam int unsigned Depth = 1 << FIFO_AW;

    typedef enum logic [1:0] {CapIdle, CapRun, CapDrain, CapDone} cap_state_e;
    typedef enum logic {WrIdle, WrReq} wr_state_e;

    cap_state_e cap_q, cap_d;
    wr_state_e  wr_q, wr_d;

    logic [ADC_WIDTH-1:0] mem [Depth];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic                 fifo_full, fifo_empty;

    logic [21:0] len_q, acc_q, addr_q, sw_q, addr_next, wrap_last;
    logic [15:0] data_q;
    logic        overflow_q;

    logic cap_start, push, drop, load, pop;

    assign fifo_full  = (count_q == (FIFO_AW + 1)'(Depth));
    assign fifo_empty = (count_q == '0);

    assign sdram.req     = (wr_q == WrReq);
    assign sdram.wnr     = 1'b1;
    assign sdram.address = addr_q;
    assign sdram.data    = data_q;

    assign active          = (cap_q == CapRun) || (cap_q == CapDrain);
    assign done            = (cap_q == CapDone);
    assign overflow        = overflow_q;
    assign samples_written = sw_q;

    // Capture FSM next state; full is judged before any same-edge pop, so such samples drop.
    always_comb begin
        cap_d     = cap_q;
        cap_start = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        unique case (cap_q)
            CapIdle, CapDone: begin
                if (start) begin
                    cap_start = 1'b1;
                    cap_d     = (length == '0) ? CapDone : CapRun;
                end
            end
            CapRun: begin
                push = adc_valid && !fifo_full;
                drop = adc_valid && fifo_full;
                if (stop) begin
                    cap_d = CapDrain;
                end else if (!WrapEn && push && (acc_q + 22'd1 == len_q)) begin
                    cap_d = CapDrain;
                end
            end
            CapDrain: begin
                if (fifo_empty && (wr_q == WrIdle)) cap_d = CapDone;
            end
        endcase
    end

    // Capture state, window length, accepted count and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q      <= CapIdle;
            len_q      <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            if (cap_start) begin
                len_q      <= length;
                acc_q      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) acc_q <= acc_q + 22'd1;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= adc_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Write FSM next state and the next write address.
    always_comb begin
        wr_d      = wr_q;
        load      = 1'b0;
        pop       = 1'b0;
        wrap_last = BASE_ADDR + len_q - 22'd1;
        addr_next = (WrapEn && (addr_q == wrap_last)) ? BASE_ADDR : addr_q + 22'd1;
        unique case (wr_q)
            WrIdle: begin
                if (!fifo_empty && !sdram.busy) begin
                    wr_d = WrReq;
                    load = 1'b1;
                end
            end
            WrReq: begin
                if (sdram.ack) begin
                    wr_d = WrIdle;
                    pop  = 1'b1;
                end
            end
        endcase
    end

    // Write state, held address/data and acknowledged-write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= WrIdle;
            addr_q <= BASE_ADDR;
            data_q <= '0;
            sw_q   <= '0;
        end else begin
            wr_q <= wr_d;
            if (cap_start) begin
                addr_q <= BASE_ADDR;
                sw_q   <= '0;
            end else begin
                if (load) data_q <= 16'(mem[rd_ptr_q]);
                if (pop) begin
                    addr_q <= addr_next;
                    if (!(WrapEn && (sw_q == 22'h3FFFFF))) sw_q <= sw_q + 22'd1;
                end
            end
        end
    end

endmodule
